// File: rtl/servo_pwm_gen.sv
// Frame-synchronous hobby-servo PWM generator with a clamped, double-buffered width command.
// Outputs are registered one cycle after the inputs are sampled; commands are always accepted, with no backpressure.
module servo_pwm_gen #(
   parameter int WIDTH      = 12,
   parameter int PERIOD_CYC = 1000000,
   parameter int MIN_CYC    = 50000,
   parameter int SCALE      = 12,
   parameter int MAX_CYC    = 100000,
   parameter int CNT_W      = 20
) (
   input  logic             clk_i,
   input  logic             reset,
   input  logic             enable_i,
   input  logic [WIDTH-1:0] cmd_i,
   input  logic             cmd_valid_i,
   output logic             pwm_o,
   output logic             frame_start_o,
   output logic             cmd_pending_o,
   output logic [CNT_W-1:0] width_o
);

   localparam logic [CNT_W:0]   MIN_EXT   = (CNT_W+1)'(MIN_CYC);
   localparam logic [CNT_W:0]   MAX_EXT   = (CNT_W+1)'(MAX_CYC);
   localparam logic [CNT_W:0]   SCALE_EXT = (CNT_W+1)'(SCALE);
   localparam logic [CNT_W-1:0] MIN_W     = CNT_W'(MIN_CYC);
   localparam logic [CNT_W-1:0] MAX_W     = CNT_W'(MAX_CYC);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(PERIOD_CYC - 1);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_LOW  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_boundary;
   logic [CNT_W:0]   w_sum;
   logic [CNT_W-1:0] w_cmd_width;
   logic [CNT_W-1:0] r_shadow;
   logic [CNT_W-1:0] r_width;
   logic             r_pwm;
   logic             r_frame_start;
   logic             r_pending;

   // One extra bit keeps MIN + cmd*SCALE from wrapping before the clamp.
   assign w_sum       = MIN_EXT + (CNT_W+1)'(cmd_i) * SCALE_EXT;
   assign w_cmd_width = (w_sum > MAX_EXT) ? MAX_W : w_sum[CNT_W-1:0];

   always_ff @(posedge clk_i) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_boundary  = 1'b0;
      if (!enable_i) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state_nxt = S_HIGH;
               w_cnt_nxt   = '0;
               w_boundary  = 1'b1;
            end
            S_HIGH: begin
               w_cnt_nxt = r_cnt + ONE;
               if (r_cnt == r_width - ONE) begin
                  w_state_nxt = S_LOW;
               end
            end
            S_LOW: begin
               if (r_cnt == LAST_CNT) begin
                  w_state_nxt = S_HIGH;
                  w_cnt_nxt   = '0;
                  w_boundary  = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + ONE;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // The boundary latches the old shadow, so a coincident strobe waits for the next frame.
   always_ff @(posedge clk_i) begin
      if (reset) begin
         r_pwm         <= 1'b0;
         r_frame_start <= 1'b0;
         r_pending     <= 1'b0;
         r_width       <= MIN_W;
         r_shadow      <= MIN_W;
      end else begin
         r_pwm         <= (w_state_nxt == S_HIGH);
         r_frame_start <= w_boundary;
         if (w_boundary) begin
            r_width <= r_shadow;
         end
         if (cmd_valid_i) begin
            r_shadow  <= w_cmd_width;
            r_pending <= 1'b1;
         end else if (w_boundary) begin
            r_pending <= 1'b0;
         end
      end
   end

   assign pwm_o         = r_pwm;
   assign frame_start_o = r_frame_start;
   assign cmd_pending_o = r_pending;
   assign width_o       = r_width;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed test-plan walk followed by random enable/command/reset traffic, both scored against a frame-position model.
module tb_servo_pwm_gen;

   localparam int P   = 100;
   localparam int MN  = 10;
   localparam int SC  = 4;
   localparam int MX  = 50;

   logic       clk_i = 1'b0;
   logic       reset = 1'b1;
   logic       enable_i = 1'b0;
   logic [3:0] cmd_i = 4'd0;
   logic       cmd_valid_i = 1'b0;
   logic       pwm_o;
   logic       frame_start_o;
   logic       cmd_pending_o;
   logic [7:0] width_o;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: position inside the current frame and the two width registers.
   bit m_run  = 1'b0;
   int m_pos  = 0;
   int m_cur  = MN;
   int m_shd  = MN;
   bit m_pend = 1'b0;

   servo_pwm_gen #(
      .WIDTH(4), .PERIOD_CYC(P), .MIN_CYC(MN), .SCALE(SC), .MAX_CYC(MX), .CNT_W(8)
   ) dut (
      .clk_i(clk_i), .reset(reset), .enable_i(enable_i), .cmd_i(cmd_i),
      .cmd_valid_i(cmd_valid_i), .pwm_o(pwm_o), .frame_start_o(frame_start_o),
      .cmd_pending_o(cmd_pending_o), .width_o(width_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic model_step();
      bit bnd;
      if (reset) begin
         m_run = 1'b0; m_pos = 0; m_cur = MN; m_shd = MN; m_pend = 1'b0;
      end else begin
         bnd = enable_i && (!m_run || m_pos == P - 1);
         if (!enable_i) begin
            m_run = 1'b0; m_pos = 0;
         end else if (!m_run) begin
            m_run = 1'b1; m_pos = 0;
         end else begin
            m_pos = (m_pos + 1) % P;
         end
         if (bnd) begin
            m_cur = m_shd; m_pend = 1'b0;
         end
         if (cmd_valid_i) begin
            m_shd = MN + int'(cmd_i) * SC;
            if (m_shd > MX) m_shd = MX;
            m_pend = 1'b1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      model_step();
      @(negedge clk_i);
      check("m_pwm",   {31'd0, pwm_o},         {31'd0, (m_run && m_pos < m_cur)});
      check("m_fs",    {31'd0, frame_start_o}, {31'd0, (m_run && m_pos == 0)});
      check("m_pend",  {31'd0, cmd_pending_o}, {31'd0, m_pend});
      check("m_width", {24'd0, width_o},       m_cur);
   endtask

   // Runs one full frame from its frame-start cycle, optionally strobing up to two commands.
   task automatic frame(input int s1, input int c1, input int s2, input int c2,
                        output int hi, output logic pend_last);
      hi = 0;
      pend_last = 1'b0;
      for (int i = 0; i < P; i++) begin
         if (pwm_o) hi++;
         if (i == P - 1) pend_last = cmd_pending_o;
         cmd_valid_i = (i == s1) || (i == s2);
         cmd_i = (i == s2) ? 4'(c2) : 4'(c1);
         tick();
      end
      cmd_valid_i = 1'b0;
   endtask

   initial begin
      int   hi;
      logic pl;

      reset = 1'b1;
      repeat (3) tick();
      check("rst_pwm",   {31'd0, pwm_o}, 32'd0);
      check("rst_fs",    {31'd0, frame_start_o}, 32'd0);
      check("rst_pend",  {31'd0, cmd_pending_o}, 32'd0);
      check("rst_width", {24'd0, width_o}, 32'd10);

      reset = 1'b0;
      enable_i = 1'b1;
      tick();
      check("first_fs",  {31'd0, frame_start_o}, 32'd1);
      check("first_pwm", {31'd0, pwm_o}, 32'd1);

      frame(-1, 0, -1, 0, hi, pl);
      check("f1_high", hi, 32'd10);
      check("f1_period", {31'd0, frame_start_o}, 32'd1);

      frame(20, 5, -1, 0, hi, pl);
      check("f2_high", hi, 32'd10);
      check("f2_pend", {31'd0, pl}, 32'd1);
      check("f2_width_next", {24'd0, width_o}, 32'd30);
      check("f2_pend_clr", {31'd0, cmd_pending_o}, 32'd0);

      frame(-1, 0, -1, 0, hi, pl);
      check("f3_high", hi, 32'd30);

      frame(10, 15, -1, 0, hi, pl);
      check("f4_high", hi, 32'd30);
      check("clamp_width", {24'd0, width_o}, 32'd50);

      frame(10, 2, 40, 7, hi, pl);
      check("f5_high", hi, 32'd50);
      check("last_write", {24'd0, width_o}, 32'd38);

      frame(0, 3, -1, 0, hi, pl);
      check("coincide_high", hi, 32'd38);
      check("coincide_pend", {31'd0, pl}, 32'd1);
      check("coincide_next", {24'd0, width_o}, 32'd22);

      repeat (4) tick();
      enable_i = 1'b0;
      tick();
      check("cut_pwm", {31'd0, pwm_o}, 32'd0);
      repeat (3) tick();
      check("idle_pwm", {31'd0, pwm_o}, 32'd0);
      enable_i = 1'b1;
      tick();
      check("reen_fs",  {31'd0, frame_start_o}, 32'd1);
      check("reen_pwm", {31'd0, pwm_o}, 32'd1);
      frame(-1, 0, -1, 0, hi, pl);
      check("reen_high", hi, 32'd22);
      check("reen_period", {31'd0, frame_start_o}, 32'd1);

      for (int i = 0; i < 60; i++) begin
         cmd_valid_i = (i == 5);
         cmd_i = 4'd9;
         tick();
      end
      cmd_valid_i = 1'b0;
      check("pre_rst_pend", {31'd0, cmd_pending_o}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_pwm",   {31'd0, pwm_o}, 32'd0);
      check("midrst_pend",  {31'd0, cmd_pending_o}, 32'd0);
      check("midrst_width", {24'd0, width_o}, 32'd10);
      tick();
      check("postrst_fs", {31'd0, frame_start_o}, 32'd1);
      frame(-1, 0, -1, 0, hi, pl);
      check("postrst_high", hi, 32'd10);

      for (int i = 0; i < 3000; i++) begin
         enable_i    = ($urandom_range(0, 199) != 0);
         cmd_valid_i = ($urandom_range(0, 29) == 0);
         cmd_i       = 4'($urandom_range(0, 15));
         reset       = ($urandom_range(0, 999) == 0);
         tick();
      end
      reset = 1'b0;
      cmd_valid_i = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/servo_pwm_gen.md
Name: servo_pwm_gen

Overview:
- Downstream neighbour of the PID controller.
- Takes the 12-bit servo command produced by the PID stage and generates the hobby-servo PWM waveform on the output pin.
- Command is double-buffered: a new value is accepted at any time but applied only at a frame boundary, so a pulse is never truncated or stretched mid-frame.
- Replaces the free-running comparator approach with a frame-synchronous, clamped, enable-gated generator.

Parameters:
- WIDTH, 12, command width in bits.
- PERIOD_CYC, 1000000, frame length in clk_i cycles (20 ms at 50 MHz).
- MIN_CYC, 50000, pulse width for command 0 (1 ms).
- SCALE, 12, clk_i cycles added per command LSB.
- MAX_CYC, 100000, upper clamp on pulse width (2 ms); must satisfy MIN_CYC <= MAX_CYC < PERIOD_CYC.
- CNT_W, 20, counter width; must hold PERIOD_CYC-1.

Ports:
- clk_i  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable_i  input  1  1 = generate frames; 0 = hold output low.
- cmd_i  input  WIDTH  servo command from PID (unsigned).
- cmd_valid_i  input  1  one-cycle strobe qualifying cmd_i.
- pwm_o  output  1  servo PWM pin.
- frame_start_o  output  1  one-cycle pulse on the first high cycle of each frame.
- cmd_pending_o  output  1  shadow holds a command not yet applied.
- width_o  output  CNT_W  pulse width (cycles) currently in force.

Behaviour:
- One clock, clk_i. reset is synchronous and active-high.
- Reset values:
  - pwm_o = 0, frame_start_o = 0, cmd_pending_o = 0.
  - width_o = MIN_CYC; shadow width = MIN_CYC.
  - frame counter = 0; state = IDLE.
- Width computation, on cmd_valid_i:
  - w = MIN_CYC + cmd_i*SCALE, computed at CNT_W+1 bits with no overflow.
  - If w > MAX_CYC, w = MAX_CYC.
  - w is registered into the shadow and cmd_pending_o is set next cycle.
  - A later cmd_valid_i before the frame boundary overwrites the shadow; last write wins.
- States:
  - IDLE: pwm_o = 0, counter held at 0. Go to HIGH on the first cycle enable_i = 1.
  - HIGH: pwm_o = 1, counter increments. Go to LOW when counter = width_o-1.
  - LOW: pwm_o = 0, counter increments. When counter = PERIOD_CYC-1, counter wraps to 0 and the next frame begins in HIGH.
  - enable_i = 0 in any state: next cycle state = IDLE, pwm_o = 0, counter = 0. The current pulse is cut; this is the only case a pulse may be short.
- Frame boundary (entry to HIGH, from IDLE or from the LOW wrap):
  - width_o <= shadow; cmd_pending_o <= 0; frame_start_o = 1 for exactly that cycle.
  - pwm_o rises in that same cycle.
  - If cmd_valid_i coincides with the boundary cycle, the new command is NOT used in this frame; it lands in the shadow and cmd_pending_o = 1.
- Pulse and frame timing:
  - pwm_o is high for exactly width_o cycles per frame.
  - Frame length is exactly PERIOD_CYC cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset mid-frame: all reset values are applied the next cycle. The shadow command is discarded.

Test Plan:
Bench parameters: WIDTH=4, PERIOD_CYC=100, MIN_CYC=10, SCALE=4, MAX_CYC=50, CNT_W=8.
1. Reset, enable_i = 1, no command -> pwm_o high 10 cycles, low 90 cycles, repeating. frame_start_o every 100 cycles, coincident with the pwm_o rise.
2. cmd_i = 5 with strobe mid-frame -> cmd_pending_o = 1 the next cycle. Current frame stays at 10 high cycles. Next frame has 30 high cycles and width_o = 30; cmd_pending_o clears at that frame start.
3. cmd_i = 15 -> computed width 70 clamped to 50. Strobes of 2 then 7 within one frame -> next frame uses 38 (last write wins).
4. Strobe cmd_i = 3 in the same cycle frame_start_o = 1 -> that frame keeps the old width. Following frame is 22 cycles high.
5. Drop enable_i during HIGH at counter = 4 -> pwm_o = 0 next cycle, counter = 0. Re-enable -> new frame starts on the first enabled cycle with frame_start_o = 1.
6. Assert reset during LOW with a command pending -> next cycle pwm_o = 0, cmd_pending_o = 0, width_o = 10. After release, frames run at 10 cycles high.
